// File: rtl/direct_lru_pkg.sv
// -----------------------------------------------------------------------------
// direct_lru_pkg
// Shared definitions for the direct-mapped cache hit/miss simulator:
//   - default geometry (2048 lines, 17-bit tags)
//   - tag-store line entry layout {valid, tag}
//   - controller state encoding
//   - progress-bar thermometer helper
// -----------------------------------------------------------------------------
package direct_lru_pkg;

  localparam int DEFAULT_INDEX_W = 11;
  localparam int DEFAULT_TAG_W   = 17;
  localparam int LED_W           = 15;
  localparam int INST_W          = 21;
  localparam int CNT_W           = 32;

  // One tag-store line at the default tag width.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_TAG_W-1:0] tag;
  } line_entry_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  // Thermometer code: bit i is set when level exceeds i.
  function automatic logic [LED_W-1:0] led_thermo(input logic [3:0] level);
    logic [LED_W-1:0] bar;
    bar = '0;
    for (int i = 0; i < LED_W; i++) begin
      bar[i] = (level > 4'(i));
    end
    return bar;
  endfunction

endpackage

// File: rtl/direct_lru_tagram.sv
// -----------------------------------------------------------------------------
// direct_lru_tagram
// Single-port synchronous RAM holding one {valid, tag} entry per cache line.
// A write takes priority; a read (en && !we) returns data one cycle later on
// rdata, which holds its value until the next read.
//
// Ports:
//   clk     in   clock
//   resetn  in   async active-low reset (clears the read register only)
//   en      in   port enable
//   we      in   write enable (qualified by en)
//   addr    in   ADDR_W line address
//   wdata   in   DATA_W write data
//   rdata   out  DATA_W registered read data
// -----------------------------------------------------------------------------
module direct_lru_tagram
  import direct_lru_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_INDEX_W,
  parameter int DATA_W = DEFAULT_TAG_W + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_r;

  // Storage array write port; contents are cleared by the owner's INIT sweep.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port with one cycle of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= '0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/direct_lru.sv
// -----------------------------------------------------------------------------
// direct_lru
// Direct-mapped cache hit/miss simulator. Each accepted trace record is looked
// up in an on-chip tag store; hits and misses are tallied in 32-bit wrapping
// counters and misses allocate the line (read and write alike).
//
// Sequence per record: IDLE (accept + issue read) -> LOOKUP (classify)
// -> UPDATE (counters, allocate on miss) -> IDLE. After reset the tag store
// is swept to invalid one line per cycle in INIT.
//
// Ports:
//   clk             in   system clock
//   resetn          in   async active-low reset
//   LRUTag          in   TAG_W tag of the access
//   LRUIndex        in   INDEX_W line index of the access
//   LRULoadStore    in   1 = store, 0 = load
//   LRUInst         in   21-bit instruction sequence number
//   LRULineReady    in   one-cycle record strobe
//   busy            out  high during INIT and while a record is processed
//   accessesTotal .. missTotal  out  32-bit statistics counters
//   led             out  15-bit progress bar
//
// Build option: define DIRECT_LRU_LED_EN to drive led as a thermometer of
// LRUInst[20:17] of the latest accepted record; otherwise led is held at 0.
// -----------------------------------------------------------------------------
module direct_lru
  import direct_lru_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int TAG_W   = DEFAULT_TAG_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [TAG_W-1:0]   LRUTag,
  input  logic [INDEX_W-1:0] LRUIndex,
  input  logic               LRULoadStore,
  input  logic [20:0]        LRUInst,
  input  logic               LRULineReady,
  output logic               busy,
  output logic [31:0]        accessesTotal,
  output logic [31:0]        evictionTotal,
  output logic [31:0]        readHitTotal,
  output logic [31:0]        writeHitTotal,
  output logic [31:0]        readMissTotal,
  output logic [31:0]        writeMissTotal,
  output logic [31:0]        hitTotal,
  output logic [31:0]        missTotal,
  output logic [14:0]        led
);

  // Line entry at this instance's tag width.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } line_t;

  localparam int LINE_W = TAG_W + 1;

  // FSM and request latch
  state_e             state_r;
  state_e             state_next_s;
  logic [INDEX_W-1:0] init_idx_r;
  logic [TAG_W-1:0]   tag_r;
  logic [INDEX_W-1:0] index_r;
  logic               store_r;
  logic               hit_r;
  logic               evict_r;
  logic               busy_r;
  logic               accept_s;

  // Tag store port
  logic               ram_en_s;
  logic               ram_we_s;
  logic [INDEX_W-1:0] ram_addr_s;
  logic [LINE_W-1:0]  ram_wdata_s;
  logic [LINE_W-1:0]  ram_rdata_s;
  line_t              rd_entry_s;
  line_t              alloc_entry_s;
  logic               lookup_hit_s;

  // Statistics
  logic [CNT_W-1:0]   accesses_r;
  logic [CNT_W-1:0]   eviction_r;
  logic [CNT_W-1:0]   read_hit_r;
  logic [CNT_W-1:0]   write_hit_r;
  logic [CNT_W-1:0]   read_miss_r;
  logic [CNT_W-1:0]   write_miss_r;
  logic [CNT_W-1:0]   hit_r_cnt;
  logic [CNT_W-1:0]   miss_r_cnt;

  assign accept_s      = (state_r == ST_IDLE) && LRULineReady;
  assign rd_entry_s    = line_t'(ram_rdata_s);
  assign lookup_hit_s  = rd_entry_s.valid && (rd_entry_s.tag == tag_r);
  assign alloc_entry_s = '{valid: 1'b1, tag: tag_r};

  direct_lru_tagram #(
    .ADDR_W (INDEX_W),
    .DATA_W (LINE_W)
  ) u_tagram (
    .clk    (clk),
    .resetn (resetn),
    .en     (ram_en_s),
    .we     (ram_we_s),
    .addr   (ram_addr_s),
    .wdata  (ram_wdata_s),
    .rdata  (ram_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and tag-store port control.
  always_comb begin
    state_next_s = state_r;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_addr_s   = index_r;
    ram_wdata_s  = '0;
    case (state_r)
      ST_INIT: begin
        // Invalidate one line per cycle, lowest index first.
        ram_en_s    = 1'b1;
        ram_we_s    = 1'b1;
        ram_addr_s  = init_idx_r;
        ram_wdata_s = '0;
        if (&init_idx_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        // The read is issued straight from the inputs so data is ready in LOOKUP.
        ram_addr_s = LRUIndex;
        if (LRULineReady) begin
          ram_en_s     = 1'b1;
          state_next_s = ST_LOOKUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        state_next_s = ST_UPDATE;
      end
      ST_UPDATE: begin
        // Allocate on any miss; a hit leaves the line untouched.
        ram_addr_s  = index_r;
        ram_wdata_s = alloc_entry_s;
        if (!hit_r) begin
          ram_en_s = 1'b1;
          ram_we_s = 1'b1;
        end else begin
          ram_en_s = 1'b0;
          ram_we_s = 1'b0;
        end
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // INIT sweep address; restarts from 0 on every reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_idx_r <= '0;
    end else if (state_r == ST_INIT) begin
      init_idx_r <= init_idx_r + {{(INDEX_W-1){1'b0}}, 1'b1};
    end
  end

  // Busy flag, registered from the next state so it falls on the first IDLE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r <= 1'b1;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  // Latch the accepted record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_r   <= '0;
      index_r <= '0;
      store_r <= 1'b0;
    end else if (accept_s) begin
      tag_r   <= LRUTag;
      index_r <= LRUIndex;
      store_r <= LRULoadStore;
    end
  end

  // Classify the access once the tag-store read data has returned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_r   <= 1'b0;
      evict_r <= 1'b0;
    end else if (state_r == ST_LOOKUP) begin
      hit_r   <= lookup_hit_s;
      evict_r <= rd_entry_s.valid && !lookup_hit_s;
    end
  end

  // Statistics counters, updated at the end of UPDATE; they wrap at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      accesses_r   <= 32'd0;
      eviction_r   <= 32'd0;
      read_hit_r   <= 32'd0;
      write_hit_r  <= 32'd0;
      read_miss_r  <= 32'd0;
      write_miss_r <= 32'd0;
      hit_r_cnt    <= 32'd0;
      miss_r_cnt   <= 32'd0;
    end else if (state_r == ST_UPDATE) begin
      accesses_r <= accesses_r + 32'd1;
      if (hit_r) begin
        hit_r_cnt <= hit_r_cnt + 32'd1;
        if (store_r) begin
          write_hit_r <= write_hit_r + 32'd1;
        end else begin
          read_hit_r <= read_hit_r + 32'd1;
        end
      end else begin
        miss_r_cnt <= miss_r_cnt + 32'd1;
        if (store_r) begin
          write_miss_r <= write_miss_r + 32'd1;
        end else begin
          read_miss_r <= read_miss_r + 32'd1;
        end
        if (evict_r) begin
          eviction_r <= eviction_r + 32'd1;
        end
      end
    end
  end

  assign busy           = busy_r;
  assign accessesTotal  = accesses_r;
  assign evictionTotal  = eviction_r;
  assign readHitTotal   = read_hit_r;
  assign writeHitTotal  = write_hit_r;
  assign readMissTotal  = read_miss_r;
  assign writeMissTotal = write_miss_r;
  assign hitTotal       = hit_r_cnt;
  assign missTotal      = miss_r_cnt;

`ifdef DIRECT_LRU_LED_EN
  // Only the top four instruction bits feed the bar.
  logic             unused_inst_s;
  logic [LED_W-1:0] led_r;

  assign unused_inst_s = ^LRUInst[16:0];

  // Progress bar register; it also serves as the instruction latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_r <= '0;
    end else if (accept_s) begin
      led_r <= led_thermo(LRUInst[20:17]);
    end
  end

  assign led = led_r;
`else
  logic unused_inst_s;

  assign unused_inst_s = ^LRUInst;
  assign led           = 15'd0;
`endif

endmodule

// File: tb/tb_direct_lru.sv
`timescale 1ns/1ps
module tb_direct_lru;
  import direct_lru_pkg::*;

  localparam int IW    = 11;
  localparam int TW    = 17;
  localparam int LINES = 1 << IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [TW-1:0] LRUTag;
  logic [IW-1:0] LRUIndex;
  logic          LRULoadStore;
  logic [20:0]   LRUInst;
  logic          LRULineReady;
  logic          busy;
  logic [31:0]   accessesTotal, evictionTotal, readHitTotal, writeHitTotal;
  logic [31:0]   readMissTotal, writeMissTotal, hitTotal, missTotal;
  logic [14:0]   led;

  direct_lru #(.INDEX_W(IW), .TAG_W(TW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .LRUTag         (LRUTag),
    .LRUIndex       (LRUIndex),
    .LRULoadStore   (LRULoadStore),
    .LRUInst        (LRUInst),
    .LRULineReady   (LRULineReady),
    .busy           (busy),
    .accessesTotal  (accessesTotal),
    .evictionTotal  (evictionTotal),
    .readHitTotal   (readHitTotal),
    .writeHitTotal  (writeHitTotal),
    .readMissTotal  (readMissTotal),
    .writeMissTotal (writeMissTotal),
    .hitTotal       (hitTotal),
    .missTotal      (missTotal),
    .led            (led)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain array-of-lines cache and integer tallies.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int unsigned m_acc, m_evict, m_rh, m_wh, m_rm, m_wm;
  logic [14:0] m_led;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_acc = 0; m_evict = 0; m_rh = 0; m_wh = 0; m_rm = 0; m_wm = 0;
    m_led = 15'd0;
  endtask

  task automatic model_access(input int unsigned tag, input int unsigned idx,
                              input bit st, input int unsigned inst);
    int unsigned lvl;
    m_acc++;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (st) m_wh++; else m_rh++;
    end else begin
      if (m_valid[idx]) m_evict++;
      if (st) m_wm++; else m_rm++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    lvl = inst >> 17;
`ifdef DIRECT_LRU_LED_EN
    if (lvl >= 15) m_led = 15'h7FFF;
    else           m_led = 15'((32'd1 << lvl) - 32'd1);
`else
    m_led = 15'd0;
`endif
  endtask

  task automatic check_counters(input string pfx);
    check_eq({pfx, "_acc"},   accessesTotal,  m_acc);
    check_eq({pfx, "_evict"}, evictionTotal,  m_evict);
    check_eq({pfx, "_rhit"},  readHitTotal,   m_rh);
    check_eq({pfx, "_whit"},  writeHitTotal,  m_wh);
    check_eq({pfx, "_rmiss"}, readMissTotal,  m_rm);
    check_eq({pfx, "_wmiss"}, writeMissTotal, m_wm);
    check_eq({pfx, "_hit"},   hitTotal,       m_rh + m_wh);
    check_eq({pfx, "_miss"},  missTotal,      m_rm + m_wm);
    check_eq({pfx, "_led"},   {17'd0, led},   {17'd0, m_led});
  endtask

  // Counts clock edges after reset release until busy drops (bounded).
  task automatic wait_init(input string name);
    int  cycles;
    bit  done;
    cycles = 0;
    done   = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (!busy) done = 1'b1;
    end
    check_eq(name, cycles, 32'd2048);
    @(negedge clk);
  endtask

  // Called at a negedge; returns three cycles later with the access counted.
  task automatic do_access(input int unsigned tag, input int unsigned idx,
                           input bit st, input int unsigned inst, input bit chk_busy);
    LRUTag       = TW'(tag);
    LRUIndex     = IW'(idx);
    LRULoadStore = st;
    LRUInst      = 21'(inst);
    LRULineReady = 1'b1;
    @(negedge clk);
    LRULineReady = 1'b0;
    if (chk_busy) check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    if (chk_busy) check_eq("busy_back_idle", {31'd0, busy}, 32'd0);
    model_access(tag, idx, st, inst);
  endtask

  initial begin
    int unsigned tag, idx, inst;
    bit          st;
    int unsigned acc_before;

    resetn       = 1'b0;
    LRUTag       = '0;
    LRUIndex     = '0;
    LRULoadStore = 1'b0;
    LRUInst      = '0;
    LRULineReady = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("busy_in_reset", {31'd0, busy}, 32'd1);
    check_counters("reset");
    resetn = 1'b1;
    wait_init("init_len");
    check_counters("post_init");

    // Directed: load miss then hit on the same line.
    do_access(32'h1, 5, 1'b0, 0, 1'b1);
    check_eq("d1_rmiss", readMissTotal, 32'd1);
    do_access(32'h1, 5, 1'b0, 0, 1'b1);
    check_eq("d2_rhit", readHitTotal, 32'd1);
    check_eq("d2_acc", accessesTotal, 32'd2);
    check_eq("d2_evict", evictionTotal, 32'd0);

    // Directed: store with a new tag evicts, then a load of that tag hits.
    do_access(32'h2, 5, 1'b1, 0, 1'b1);
    check_eq("d3_wmiss", writeMissTotal, 32'd1);
    check_eq("d3_evict", evictionTotal, 32'd1);
    do_access(32'h2, 5, 1'b0, 0, 1'b1);
    check_eq("d4_rhit", readHitTotal, 32'd2);
    check_counters("directed");

    // A strobe one cycle after an accepted strobe is dropped.
    acc_before   = accessesTotal;
    LRUTag       = TW'(3);
    LRUIndex     = IW'(9);
    LRULoadStore = 1'b0;
    LRUInst      = 21'd0;
    LRULineReady = 1'b1;
    @(negedge clk);
    LRUTag       = TW'(7);
    LRUIndex     = IW'(10);
    LRULoadStore = 1'b1;
    @(negedge clk);
    LRULineReady = 1'b0;
    @(negedge clk);
    model_access(3, 9, 1'b0, 0);
    check_eq("drop_acc_delta", accessesTotal - acc_before, 32'd1);
    check_counters("drop");

    // Progress bar from the top instruction bits.
    do_access(32'h4, 100, 1'b0, 32'h1C0000, 1'b0);
`ifdef DIRECT_LRU_LED_EN
    check_eq("led_level14", {17'd0, led}, 32'h3FFF);
`else
    check_eq("led_disabled", {17'd0, led}, 32'h0);
`endif

    // Random records at minimum spacing; small tag/index pools force reuse.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        tag = $urandom_range(0, (1 << TW) - 1);
        idx = $urandom_range(0, LINES - 1);
      end else begin
        tag = $urandom_range(0, 3);
        idx = $urandom_range(0, 15);
      end
      st   = 1'($urandom_range(0, 1));
      inst = $urandom_range(0, 32'h1FFFFF);
      do_access(tag, idx, st, inst, 1'b0);
      check_counters("rand");
    end
    check_eq("inv_hit",  hitTotal,      readHitTotal + writeHitTotal);
    check_eq("inv_miss", missTotal,     readMissTotal + writeMissTotal);
    check_eq("inv_acc",  accessesTotal, hitTotal + missTotal);

    // Reset in the middle of an access: it is discarded and INIT reruns.
    LRUTag       = TW'(5);
    LRUIndex     = IW'(7);
    LRULoadStore = 1'b1;
    LRULineReady = 1'b1;
    @(negedge clk);
    LRULineReady = 1'b0;
    resetn       = 1'b0;
    @(negedge clk);
    model_reset();
    check_eq("midrst_busy", {31'd0, busy}, 32'd1);
    check_counters("midrst");
    resetn = 1'b1;
    wait_init("reinit_len");
    do_access(32'h1, 5, 1'b0, 0, 1'b1);
    check_eq("after_reinit_rmiss", readMissTotal, 32'd1);
    check_counters("after_reinit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/direct_lru.md
# direct_lru

Direct-mapped cache hit/miss simulator. It consumes one decoded memory-trace record per strobe and keeps a 2048-line tag store with 17-bit tags. It also keeps 32-bit statistics counters and drives a 15-LED progress bar. It sits between the trace decoder, which supplies tag, index, load/store and instruction number, and the IO/display logic, which reads the counters. The external DDR2 path is out of scope; the tag store is on-chip.

## Interface
Parameters:
- INDEX_W, 11: index width; the cache has 2^INDEX_W lines.
- TAG_W, 17: tag width.

Ports:
- clk  in  1  system clock. One clock domain: all logic runs on `clk`.
- resetn  in  1  reset, asynchronous and active-low.
- LRUTag  in  TAG_W  tag of the access.
- LRUIndex  in  INDEX_W  line index of the access.
- LRULoadStore  in  1  1 = store, 0 = load.
- LRUInst  in  21  instruction sequence number of the record.
- LRULineReady  in  1  one-cycle strobe: the record is valid.
- busy  out  1  high while initialising or processing; strobes arriving then are dropped.
- accessesTotal, evictionTotal, readHitTotal, writeHitTotal, readMissTotal, writeMissTotal, hitTotal, missTotal  out  32 each  statistics counters.
- led  out  15  progress bar.

## Operation
States:
- INIT: after reset, write valid=0 to every line, index 0 up to 2^INDEX_W−1, one line per cycle, then go to IDLE.
- IDLE: on `LRULineReady`, latch tag, index, load/store and inst, issue the tag-store read, and go to LOOKUP.
- LOOKUP: the read data is available. A hit is valid && stored tag == latched tag. Go to UPDATE.
- UPDATE:
  - Every access: `accessesTotal` +1.
  - Hit: `readHitTotal` or `writeHitTotal` +1 (by load/store), and `hitTotal` +1.
  - Miss: `readMissTotal` or `writeMissTotal` +1 (by load/store), and `missTotal` +1. Write {valid=1, tag} into the line; allocate on both read and write misses.
  - Miss where the line was valid: `evictionTotal` +1.
  - Return to IDLE.

Rules:
- Hits leave the tag store unchanged.
- Counters wrap modulo 2^32; they do not saturate.
- Invariants: `hitTotal` = `readHitTotal` + `writeHitTotal`; `missTotal` = `readMissTotal` + `writeMissTotal`; `accessesTotal` = `hitTotal` + `missTotal`.
- Progress bar: `led[i]` = (latched inst[20:17] > i), for i = 0..14. This is a thermometer code of the latest accepted record.

## Timing
- Reset: all counters 0, `led` 0, `busy` 1, state INIT.
- INIT lasts 2^INDEX_W cycles; `busy` falls on the first cycle in IDLE.
- The tag store is a synchronous-read RAM with 1-cycle read latency.
- A strobe sampled in IDLE causes the counters to reflect that access 3 cycles later (registered at the end of UPDATE).
- `busy` is high from the cycle after acceptance through UPDATE.
- Minimum strobe spacing is 3 cycles. A strobe arriving while `busy` is high is ignored and not counted.
- Accesses to the same index back-to-back at 3-cycle spacing see the prior update, because the write completes in UPDATE before the next read is issued.
- Reset asserted at any time aborts the current access and restarts INIT; the partial access is not counted.

## Configuration
- DIRECT_LRU_LED_EN defined: `led` is driven as the progress bar described above.
- Not defined: `led` is tied to 0 and the inst latch is removed. Counter behaviour is identical in both cases.

## Structure
- Shared package `direct_lru_pkg`:
  - INDEX_W and TAG_W defaults.
  - Line entry typedef {valid, tag}.
  - FSM state enum {INIT, IDLE, LOOKUP, UPDATE}.
- One sub-module, `direct_lru_tagram`: single-port synchronous RAM of 2^INDEX_W × (TAG_W+1), with write enable.
- Counters and the FSM live in the top module.

## Test plan
- Reset release: `busy` stays 1 for exactly 2048 cycles; all counters read 0.
- Load tag 0x00001, index 5, then the same load again: readMiss=1, readHit=1, accesses=2, eviction=0.
- Store tag 0x00002, index 5 after the above: writeMiss=1, eviction=1; a following load of tag 0x00002, index 5 gives readHit=2.
- Strobe 1 cycle after an accepted strobe: the second strobe is dropped and accesses increments by exactly 1.
- 1000 random records at 3-cycle spacing: counters match a scoreboard model, and the three sum invariants hold.
- LRUInst = 0x1C0000 (bits [20:17] = 14): led = 0x3FFF. With DIRECT_LRU_LED_EN undefined: led = 0.
